// File: rtl/mon_queue_writer_if.sv
// Record stream and memory write port of the monitor queue writer.
// The writer uses the master modport; the record source and memory side use slave.
interface mon_queue_writer_if #(
  parameter int unsigned REC_WORDS = 4
);
  logic                      rec_valid;
  logic                      rec_ready;
  logic [32*REC_WORDS-1:0]   rec_data;
  logic                      mem_req;
  logic                      mem_gnt;
  logic [3:0]                mem_we;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_data;

  modport master (
    input  rec_valid, rec_data, mem_gnt,
    output rec_ready, mem_req, mem_we, mem_addr, mem_data
  );

  modport slave (
    output rec_valid, rec_data, mem_gnt,
    input  rec_ready, mem_req, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/mon_queue_writer.sv
// Circular monitor-record queue writer: accepts fixed-size records, writes them
// word by word into data memory and tracks free/occupied slot semaphores for the NI.
module mon_queue_writer #(
  parameter int unsigned REC_WORDS = 4,
  parameter int unsigned SEM_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mon_reset_i,
  input  logic [SEM_W-1:0]     mon_sem_av_i,
  input  logic                 mon_sem_av_post_i,
  input  logic                 mon_sem_oc_wait_i,
  input  logic [SEM_W-1:0]     mon_size_i,
  input  logic [31:0]          mon_addr_i,
  output logic [SEM_W-1:0]     mon_sem_oc_o,
  output logic                 mon_active_o,
  mon_queue_writer_if.master   bus
);

  localparam int unsigned     WORD_W    = (REC_WORDS > 1) ? $clog2(REC_WORDS) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(REC_WORDS - 1);
  localparam logic [SEM_W-1:0]  SEM_MAX   = '1;

  typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [SEM_W-1:0]   sem_av_q, sem_av_d;
  logic [SEM_W-1:0]   sem_oc_q, sem_oc_d;
  logic [SEM_W-1:0]   head_q, head_d;
  logic [SEM_W-1:0]   head_inc;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [31:0]        buf_q [REC_WORDS];
  logic               accept_c;
  logic               commit_c;

  assign head_inc     = head_q + SEM_W'(1);
  assign mon_sem_oc_o = sem_oc_q;
  assign mon_active_o = (state_q != IDLE);

  // Next-state, counters and bus outputs; NI re-init overrides everything last.
  always_comb begin
    state_d        = state_q;
    sem_av_d       = sem_av_q;
    sem_oc_d       = sem_oc_q;
    head_d         = head_q;
    word_d         = word_q;
    accept_c       = 1'b0;
    commit_c       = 1'b0;
    bus.rec_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 4'h0;
    bus.mem_addr   = 32'h0;
    bus.mem_data   = 32'h0;

    unique case (state_q)
      IDLE: begin
        accept_c      = bus.rec_valid && (sem_av_q != '0) && (mon_size_i != '0) && !mon_reset_i;
        bus.rec_ready = accept_c;
        if (accept_c) begin
          word_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 4'hF;
        bus.mem_addr = mon_addr_i + ((32'(head_q) * 32'(REC_WORDS) + 32'(word_q)) << 2);
        bus.mem_data = buf_q[word_q];
        if (bus.mem_gnt) begin
          word_d = word_q + WORD_W'(1);
          if (word_q == LAST_WORD) state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_c = 1'b1;
        head_d   = (head_inc == mon_size_i) ? '0 : head_inc;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept and post in the same cycle cancel out.
    if (accept_c && !mon_sem_av_post_i) begin
      sem_av_d = sem_av_q - SEM_W'(1);
    end else if (mon_sem_av_post_i && !accept_c && (sem_av_q != SEM_MAX)) begin
      sem_av_d = sem_av_q + SEM_W'(1);
    end

    if (commit_c && !mon_sem_oc_wait_i && (sem_oc_q != SEM_MAX)) begin
      sem_oc_d = sem_oc_q + SEM_W'(1);
    end else if (mon_sem_oc_wait_i && !commit_c && (sem_oc_q != '0)) begin
      sem_oc_d = sem_oc_q - SEM_W'(1);
    end

    if (mon_reset_i) begin
      state_d  = IDLE;
      sem_av_d = mon_sem_av_i;
      sem_oc_d = '0;
      head_d   = '0;
      word_d   = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sem_av_q <= '0;
      sem_oc_q <= '0;
      head_q   <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      sem_av_q <= sem_av_d;
      sem_oc_q <= sem_oc_d;
      head_q   <= head_d;
      word_q   <= word_d;
    end
  end

  // Record buffer captured on accept; contents only reach the bus in WRITE.
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      for (int unsigned i = 0; i < REC_WORDS; i++) begin
        buf_q[i] <= bus.rec_data[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_mon_queue_writer.sv
// Directed bench for mon_queue_writer: cycle vector table plus corner-case sequences.
module tb_mon_queue_writer;

  localparam int unsigned REC_WORDS = 4;
  localparam int unsigned SEM_W     = 8;

  logic             clk;
  logic             rst;
  logic             mon_reset;
  logic [SEM_W-1:0] sem_av_in;
  logic             post;
  logic             wt;
  logic [SEM_W-1:0] size;
  logic [31:0]      base;
  logic [SEM_W-1:0] sem_oc;
  logic             active;

  int n_tests = 0;
  int n_fail  = 0;

  mon_queue_writer_if #(.REC_WORDS(REC_WORDS)) bus ();

  mon_queue_writer #(.REC_WORDS(REC_WORDS), .SEM_W(SEM_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mon_reset_i       (mon_reset),
    .mon_sem_av_i      (sem_av_in),
    .mon_sem_av_post_i (post),
    .mon_sem_oc_wait_i (wt),
    .mon_size_i        (size),
    .mon_addr_i        (base),
    .mon_sem_oc_o      (sem_oc),
    .mon_active_o      (active),
    .bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, mrst;
    logic [7:0]  sav;
    logic        post, wt;
    logic [7:0]  size;
    logic        gnt, valid;
    logic [31:0] seed;
    logic        e_ready, e_req;
    logic [31:0] e_addr, e_data;
    logic        e_active;
    logic [7:0]  e_oc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [32*REC_WORDS-1:0] mkdata(input logic [31:0] seed);
    logic [32*REC_WORDS-1:0] d;
    for (int i = 0; i < REC_WORDS; i++) d[32*i +: 32] = seed + 32'(i);
    return d;
  endfunction

  function automatic vec_t mk(input logic r, input logic mr, input logic [7:0] sav,
                              input logic p, input logic w, input logic [7:0] sz,
                              input logic g, input logic v, input logic [31:0] sd,
                              input logic er, input logic eq, input logic [31:0] ea,
                              input logic [31:0] ed, input logic eact, input logic [7:0] eoc);
    vec_t t;
    t.rst = r; t.mrst = mr; t.sav = sav; t.post = p; t.wt = w; t.size = sz;
    t.gnt = g; t.valid = v; t.seed = sd;
    t.e_ready = er; t.e_req = eq; t.e_addr = ea; t.e_data = ed; t.e_active = eact; t.e_oc = eoc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ni_reset(input logic [7:0] sav, input logic [7:0] sz, input logic [31:0] b);
    @(negedge clk);
    mon_reset = 1'b1; sem_av_in = sav; size = sz; base = b;
    bus.rec_valid = 1'b0; post = 1'b0; wt = 1'b0;
    @(negedge clk);
    mon_reset = 1'b0;
  endtask

  // Offer one record, wait (bounded) for acceptance, check every beat with grant held high.
  // Returns positioned in the COMMIT cycle.
  task automatic send_rec(input logic [31:0] seed, input logic [31:0] exp_addr);
    int n;
    n = 0;
    @(negedge clk);
    bus.rec_valid = 1'b1; bus.rec_data = mkdata(seed); #1;
    while (!bus.rec_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("send_accept", 32'(bus.rec_ready), 32'd1);
    @(negedge clk);
    bus.rec_valid = 1'b0; bus.mem_gnt = 1'b1;
    for (int k = 0; k < REC_WORDS; k++) begin
      #1;
      chk("send_req", 32'(bus.mem_req), 32'd1);
      chk("send_addr", bus.mem_addr, exp_addr + 32'(4*k));
      chk("send_data", bus.mem_data, seed + 32'(k));
      @(negedge clk);
    end
    #1;
    chk("send_commit_req", 32'(bus.mem_req), 32'd0);
    chk("send_commit_active", 32'(active), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] A, B, C, D;
    logic [31:0] E, F, G, H, I;
    A = 32'hA000_0000; B = 32'hB000_0000; C = 32'hC000_0000; D = 32'hD000_0000;
    E = 32'hE000_0000; F = 32'hF000_0000; G = 32'h6000_0000; H = 32'h7000_0000; I = 32'h8000_0000;

    rst = 1'b1; mon_reset = 1'b0; sem_av_in = '0; post = 1'b0; wt = 1'b0;
    size = '0; base = 32'h1000;
    bus.rec_valid = 1'b0; bus.rec_data = '0; bus.mem_gnt = 1'b0;

    // Two records into a 2-slot queue, stall, wrap after a post, head back to 1, commit+wait.
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,   0,0,0,0,0,0));
    vecs.push_back(mk(0,1,2,0,0,2,1,0,0,   0,0,0,0,0,0));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,A,   1,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,2,0,0,2,1,0,0, 0,1,32'h1000+32'(4*k),A+32'(k),1,0));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,B,   0,0,0,0,1,0));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,B,   1,0,0,0,0,1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,2,0,0,2,1,0,0, 0,1,32'h1010+32'(4*k),B+32'(k),1,1));
    vecs.push_back(mk(0,0,2,0,0,2,1,0,0,   0,0,0,0,1,1));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,C,   0,0,0,0,0,2));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,C,   0,0,0,0,0,2));
    vecs.push_back(mk(0,0,2,1,0,2,1,1,C,   0,0,0,0,0,2));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,C,   1,0,0,0,0,2));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,2,0,0,2,1,0,0, 0,1,32'h1000+32'(4*k),C+32'(k),1,2));
    vecs.push_back(mk(0,0,2,0,0,2,1,0,0,   0,0,0,0,1,2));
    vecs.push_back(mk(0,0,2,1,0,2,1,0,0,   0,0,0,0,0,3));
    vecs.push_back(mk(0,0,2,0,0,2,1,1,D,   1,0,0,0,0,3));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,2,0,0,2,1,0,0, 0,1,32'h1010+32'(4*k),D+32'(k),1,3));
    vecs.push_back(mk(0,0,2,0,1,2,1,0,0,   0,0,0,0,1,3));
    vecs.push_back(mk(0,0,2,0,0,2,1,0,0,   0,0,0,0,0,3));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; mon_reset = vecs[i].mrst; sem_av_in = vecs[i].sav;
      post = vecs[i].post; wt = vecs[i].wt; size = vecs[i].size;
      bus.mem_gnt = vecs[i].gnt; bus.rec_valid = vecs[i].valid;
      bus.rec_data = mkdata(vecs[i].seed);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.rec_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), vecs[i].e_req ? 32'hF : 32'h0);
      chk($sformatf("v%0d_active", i), 32'(active), 32'(vecs[i].e_active));
      chk($sformatf("v%0d_oc", i), 32'(sem_oc), 32'(vecs[i].e_oc));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_data", i), bus.mem_data, vecs[i].e_data);
      end
    end
    post = 1'b0; wt = 1'b0; bus.rec_valid = 1'b0;

    // Grant stalls on beat 1: beat held stable, single commit.
    ni_reset(8'd4, 8'd4, 32'h2000);
    @(negedge clk);
    bus.rec_valid = 1'b1; bus.rec_data = mkdata(E); bus.mem_gnt = 1'b0; #1;
    chk("stall_accept", 32'(bus.rec_ready), 32'd1);
    @(negedge clk);
    bus.rec_valid = 1'b0; bus.mem_gnt = 1'b1; #1;
    chk("stall_beat0_addr", bus.mem_addr, 32'h2000);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.mem_gnt = 1'b1;
      #1;
      chk("stall_addr", bus.mem_addr, 32'h2004);
      chk("stall_data", bus.mem_data, E + 32'd1);
      chk("stall_req", 32'(bus.mem_req), 32'd1);
      chk("stall_active", 32'(active), 32'd1);
      @(negedge clk);
    end
    #1; chk("stall_beat2_addr", bus.mem_addr, 32'h2008);
    @(negedge clk); #1; chk("stall_beat3_addr", bus.mem_addr, 32'h200C);
    @(negedge clk); #1; chk("stall_commit_active", 32'(active), 32'd1);
    @(negedge clk); #1; chk("stall_oc", 32'(sem_oc), 32'd1);
    chk("stall_idle_active", 32'(active), 32'd0);
    @(negedge clk); #1; chk("stall_oc_once", 32'(sem_oc), 32'd1);
    chk("stall_idle_req", 32'(bus.mem_req), 32'd0);

    // Wait at zero, post on accept, wait alone.
    ni_reset(8'd1, 8'd4, 32'h4000);
    @(negedge clk); wt = 1'b1;
    @(negedge clk); wt = 1'b0; #1;
    chk("wait_at_zero", 32'(sem_oc), 32'd0);
    @(negedge clk);
    bus.rec_valid = 1'b1; bus.rec_data = mkdata(H); post = 1'b1; #1;
    chk("post_accept_ready", 32'(bus.rec_ready), 32'd1);
    @(negedge clk);
    bus.rec_valid = 1'b0; post = 1'b0; bus.mem_gnt = 1'b1;
    repeat (REC_WORDS + 1) @(negedge clk);
    #1; chk("post_accept_oc", 32'(sem_oc), 32'd1);
    send_rec(I, 32'h4010);
    @(negedge clk); wt = 1'b1; #1;
    chk("wait_pre_oc", 32'(sem_oc), 32'd2);
    @(negedge clk); wt = 1'b0; #1;
    chk("wait_alone_oc", 32'(sem_oc), 32'd1);

    // NI re-init mid-record: abort, counters reloaded, queue restarts at base.
    ni_reset(8'd2, 8'd4, 32'h3000);
    send_rec(F, 32'h3000);
    @(negedge clk);
    bus.rec_valid = 1'b1; bus.rec_data = mkdata(G); #1;
    chk("abort_accept", 32'(bus.rec_ready), 32'd1);
    @(negedge clk); bus.rec_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_gnt = 1'b0; mon_reset = 1'b1; sem_av_in = 8'd5; #1;
    chk("abort_beat2_addr", bus.mem_addr, 32'h3018);
    chk("abort_pre_oc", 32'(sem_oc), 32'd1);
    @(negedge clk); mon_reset = 1'b0; #1;
    chk("abort_req", 32'(bus.mem_req), 32'd0);
    chk("abort_active", 32'(active), 32'd0);
    chk("abort_oc", 32'(sem_oc), 32'd0);
    for (int r = 0; r < 5; r++) begin
      send_rec(F + 32'(r*16), 32'h3000 + 32'((r % 4) * 16));
    end
    @(negedge clk); #1;
    chk("abort_oc_after5", 32'(sem_oc), 32'd5);
    bus.rec_valid = 1'b1; bus.rec_data = mkdata(G);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("sem_av5_exhausted", 32'(bus.rec_ready), 32'd0);
    end
    bus.rec_valid = 1'b0;

    // Disabled queue: records held back, no memory traffic.
    ni_reset(8'd3, 8'd0, 32'h5000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.rec_valid = 1'b1; #1;
      chk("size0_ready", 32'(bus.rec_ready), 32'd0);
      chk("size0_req", 32'(bus.mem_req), 32'd0);
    end
    bus.rec_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
